// File: rtl/alu_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_regfile_pkg
// Purpose : Shared definitions for the ALU / register-file pipeline:
//           ALU operation codes, post-ALU shift codes and the stage-1
//           control latch type.
// Ports   : none (package)
// Options : none
// Revision: 1.0 - initial release
// ============================================================================
package alu_regfile_pkg;

   // ALU operation codes (ALUC_IN); codes 12..15 behave as PASS_A
   localparam logic [3:0] OP_PASS_A = 4'd0;
   localparam logic [3:0] OP_PASS_B = 4'd1;
   localparam logic [3:0] OP_ADD    = 4'd2;
   localparam logic [3:0] OP_ADC    = 4'd3;
   localparam logic [3:0] OP_SUB    = 4'd4;
   localparam logic [3:0] OP_SBB    = 4'd5;
   localparam logic [3:0] OP_AND    = 4'd6;
   localparam logic [3:0] OP_OR     = 4'd7;
   localparam logic [3:0] OP_XOR    = 4'd8;
   localparam logic [3:0] OP_NOT_A  = 4'd9;
   localparam logic [3:0] OP_INC_A  = 4'd10;
   localparam logic [3:0] OP_DEC_A  = 4'd11;

   // Post-ALU shift codes (SHIFTER_SEL)
   localparam logic [1:0] SH_NONE = 2'b00;
   localparam logic [1:0] SH_SHL  = 2'b01;
   localparam logic [1:0] SH_SHR  = 2'b10;
   localparam logic [1:0] SH_ROR  = 2'b11;

   // Width-independent part of the stage-1 latch. The operand and
   // destination fields depend on module parameters, so they are kept
   // as companion flops next to this struct in the pipeline top.
   typedef struct packed {
      logic       valid;
      logic [3:0] op;
      logic [1:0] shift;
      logic       we;
   } s1_ctrl_t;

endpackage : alu_regfile_pkg
`default_nettype wire

// File: rtl/alu_shift_core.sv
`default_nettype none
// ============================================================================
// Module  : alu_shift_core
// Purpose : Combinational ALU followed by a one-bit shifter.
// Ports   : i_a, i_b  - operands (DATA_W)
//           i_cy      - carry flag from the previous executed op
//           i_op      - ALU operation code
//           i_shift   - post-ALU shift code
//           o_res     - final result (DATA_W)
//           o_cy      - new carry flag
// Options : none
// Revision: 1.0 - initial release
// ============================================================================
module alu_shift_core
   import alu_regfile_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   input  logic              i_cy,
   input  logic [3:0]        i_op,
   input  logic [1:0]        i_shift,
   output logic [DATA_W-1:0] o_res,
   output logic              o_cy
);

   // Arithmetic is carried out one bit wider; the top bit is carry/borrow.
   logic [DATA_W:0]   w_a_x;
   logic [DATA_W:0]   w_b_x;
   logic [DATA_W:0]   w_cy_x;
   logic [DATA_W:0]   w_one_x;
   logic [DATA_W:0]   w_ext;
   logic              w_arith;
   logic [DATA_W-1:0] w_logic;
   logic [DATA_W-1:0] w_alu;
   logic              w_alu_cy;

   assign w_a_x   = {1'b0, i_a};
   assign w_b_x   = {1'b0, i_b};
   assign w_cy_x  = {{DATA_W{1'b0}}, i_cy};
   assign w_one_x = {{DATA_W{1'b0}}, 1'b1};

   always_comb begin
      w_ext   = w_a_x;
      w_arith = 1'b0;
      w_logic = i_a;
      case (i_op)
         OP_PASS_B: w_logic = i_b;
         OP_ADD:    begin w_ext = w_a_x + w_b_x;          w_arith = 1'b1; end
         OP_ADC:    begin w_ext = w_a_x + w_b_x + w_cy_x; w_arith = 1'b1; end
         OP_SUB:    begin w_ext = w_a_x - w_b_x;          w_arith = 1'b1; end
         OP_SBB:    begin w_ext = w_a_x - w_b_x - w_cy_x; w_arith = 1'b1; end
         OP_AND:    w_logic = i_a & i_b;
         OP_OR:     w_logic = i_a | i_b;
         OP_XOR:    w_logic = i_a ^ i_b;
         OP_NOT_A:  w_logic = ~i_a;
         OP_INC_A:  begin w_ext = w_a_x + w_one_x;        w_arith = 1'b1; end
         OP_DEC_A:  begin w_ext = w_a_x - w_one_x;        w_arith = 1'b1; end
         default:   w_logic = i_a;
      endcase
      // Logical and pass ops leave the carry untouched.
      w_alu    = w_arith ? w_ext[DATA_W-1:0] : w_logic;
      w_alu_cy = w_arith ? w_ext[DATA_W]     : i_cy;
   end

   // A shift always replaces the ALU carry with the bit shifted out.
   always_comb begin
      o_res = w_alu;
      o_cy  = w_alu_cy;
      case (i_shift)
         SH_SHL: begin
            o_res = {w_alu[DATA_W-2:0], 1'b0};
            o_cy  = w_alu[DATA_W-1];
         end
         SH_SHR: begin
            o_res = {1'b0, w_alu[DATA_W-1:1]};
            o_cy  = w_alu[0];
         end
         SH_ROR: begin
            o_res = {w_alu[0], w_alu[DATA_W-1:1]};
            o_cy  = w_alu[0];
         end
         default: begin
            o_res = w_alu;
            o_cy  = w_alu_cy;
         end
      endcase
   end

endmodule : alu_shift_core
`default_nettype wire

// File: rtl/alu_regfile_pipe.sv
`default_nettype none
// ============================================================================
// Module  : alu_regfile_pipe
// Purpose : Two-stage register-file / ALU pipeline.
//           Stage 1: register read and operand select.
//           Stage 2: ALU + shifter, flag update, write-back.
// Ports   : CLK, RST          - clock, synchronous active-high reset
//           IN_VALID/IN_READY - micro-op handshake
//           SEL_A_RB/SEL_B_RB - source registers, C_SEL_RB - destination
//           WE_IN             - write result back to C_SEL_RB
//           Y_X_KMX_SEL       - 1 selects Y_KMX_IN as operand B
//           ALUC_IN/SHIFTER_SEL - ALU op and post-ALU shift
//           W_OUT/OUT_VALID   - result and its one-cycle valid pulse
//           CY_OUT/Z_OUT      - carry and zero flag registers
// Options : ALU_FWD_EN - when defined, the stage-2 result is bypassed into
//           the stage-1 operand mux instead of stalling for one cycle.
// Revision: 1.0 - initial release
// ============================================================================
module alu_regfile_pipe
   import alu_regfile_pkg::*;
#(
   parameter  int DATA_W = 16,
   parameter  int NREGS  = 64,
   localparam int ADDR_W = $clog2(NREGS)
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic [ADDR_W-1:0] SEL_A_RB,
   input  logic [ADDR_W-1:0] SEL_B_RB,
   input  logic [ADDR_W-1:0] C_SEL_RB,
   input  logic              WE_IN,
   input  logic              Y_X_KMX_SEL,
   input  logic [DATA_W-1:0] Y_KMX_IN,
   input  logic [3:0]        ALUC_IN,
   input  logic [1:0]        SHIFTER_SEL,
   output logic [DATA_W-1:0] W_OUT,
   output logic              OUT_VALID,
   output logic              CY_OUT,
   output logic              Z_OUT
);

   // Register file
   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];

   // Stage-1 latch
   s1_ctrl_t          s1_ctrl_q, s1_ctrl_d;
   logic [DATA_W-1:0] s1_a_q, s1_a_d;
   logic [DATA_W-1:0] s1_b_q, s1_b_d;
   logic [ADDR_W-1:0] s1_dest_q, s1_dest_d;

   // Stage-2 output registers
   logic [DATA_W-1:0] w_out_q, w_out_d;
   logic              ov_q, ov_d;
   logic              cy_q, cy_d;
   logic              z_q, z_d;

   logic [DATA_W-1:0] w_rd_a, w_rd_b;
   logic [DATA_W-1:0] w_op_a, w_op_b;
   logic [DATA_W-1:0] w_ex_res;
   logic              w_ex_cy;
   logic              w_s2_wr;
   logic              w_haz_a, w_haz_b;
   logic              w_accept;

   // ---------------- Stage 1: read / operand select ----------------
   assign w_rd_a = (SEL_A_RB == '0) ? '0 : regs_q[SEL_A_RB];
   assign w_rd_b = (SEL_B_RB == '0) ? '0 : regs_q[SEL_B_RB];

   // Excluding destination 0 covers the "R != 0" qualifier: r0 reads as 0
   // regardless of what the executing op does.
   assign w_s2_wr = s1_ctrl_q.valid && s1_ctrl_q.we && (s1_dest_q != '0);
   assign w_haz_a = w_s2_wr && (s1_dest_q == SEL_A_RB);
   assign w_haz_b = w_s2_wr && !Y_X_KMX_SEL && (s1_dest_q == SEL_B_RB);

   always_comb begin
`ifdef ALU_FWD_EN
      w_op_a   = w_haz_a ? w_ex_res : w_rd_a;
      w_op_b   = Y_X_KMX_SEL ? Y_KMX_IN : (w_haz_b ? w_ex_res : w_rd_b);
      IN_READY = !RST;
`else
      // Holding the op one cycle lets the write-back land before the read.
      w_op_a   = w_rd_a;
      w_op_b   = Y_X_KMX_SEL ? Y_KMX_IN : w_rd_b;
      IN_READY = !RST && !(IN_VALID && (w_haz_a || w_haz_b));
`endif
   end

   assign w_accept = IN_VALID && IN_READY;

   always_comb begin
      s1_ctrl_d.valid = w_accept;
      s1_ctrl_d.op    = ALUC_IN;
      s1_ctrl_d.shift = SHIFTER_SEL;
      s1_ctrl_d.we    = WE_IN;
      s1_a_d          = w_op_a;
      s1_b_d          = w_op_b;
      s1_dest_d       = C_SEL_RB;
   end

   // ---------------- Stage 2: execute / write-back ----------------
   // The carry is read here rather than in stage 1, so ADC/SBB always see
   // the flag left by the immediately preceding op.
   alu_shift_core #(
      .DATA_W (DATA_W)
   ) u_core (
      .i_a     (s1_a_q),
      .i_b     (s1_b_q),
      .i_cy    (cy_q),
      .i_op    (s1_ctrl_q.op),
      .i_shift (s1_ctrl_q.shift),
      .o_res   (w_ex_res),
      .o_cy    (w_ex_cy)
   );

   always_comb begin
      regs_d = regs_q;
      if (w_s2_wr) begin
         regs_d[s1_dest_q] = w_ex_res;
      end
      ov_d    = s1_ctrl_q.valid;
      w_out_d = s1_ctrl_q.valid ? w_ex_res : w_out_q;
      cy_d    = s1_ctrl_q.valid ? w_ex_cy  : cy_q;
      z_d     = s1_ctrl_q.valid ? (w_ex_res == '0) : z_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
         s1_ctrl_q <= '0;
         s1_a_q    <= '0;
         s1_b_q    <= '0;
         s1_dest_q <= '0;
         w_out_q   <= '0;
         ov_q      <= 1'b0;
         cy_q      <= 1'b0;
         z_q       <= 1'b0;
      end else begin
         regs_q    <= regs_d;
         s1_ctrl_q <= s1_ctrl_d;
         s1_a_q    <= s1_a_d;
         s1_b_q    <= s1_b_d;
         s1_dest_q <= s1_dest_d;
         w_out_q   <= w_out_d;
         ov_q      <= ov_d;
         cy_q      <= cy_d;
         z_q       <= z_d;
      end
   end

   assign W_OUT     = w_out_q;
   assign OUT_VALID = ov_q;
   assign CY_OUT    = cy_q;
   assign Z_OUT     = z_q;

endmodule : alu_regfile_pipe
`default_nettype wire

// File: tb/tb_alu_regfile_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_regfile_pipe
// Purpose : Scoreboard bench for alu_regfile_pipe. Stimulus pushes the
//           expected result/flags/cycle into a queue using an architectural
//           model (sequential register array + carry flag); a monitor pops
//           and compares whenever OUT_VALID is seen.
// Options : ALU_FWD_EN - selects the expected stall count on hazards.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_regfile_pipe;

   localparam int DW = 16;
   localparam int NR = 64;
   localparam int AW = 6;
   localparam int M  = 65535;
`ifdef ALU_FWD_EN
   localparam int EXP_STALL = 0;
`else
   localparam int EXP_STALL = 1;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AW-1:0] sel_a = '0, sel_b = '0, sel_c = '0;
   logic          we_in = 1'b0, ysel = 1'b0;
   logic [DW-1:0] y_in = '0;
   logic [3:0]    aluc = '0;
   logic [1:0]    shsel = '0;
   logic [DW-1:0] w_out;
   logic          out_valid, cy_out, z_out;

   alu_regfile_pipe #(.DATA_W(DW), .NREGS(NR)) dut (
      .CLK         (clk),
      .RST         (rst),
      .IN_VALID    (in_valid),
      .IN_READY    (in_ready),
      .SEL_A_RB    (sel_a),
      .SEL_B_RB    (sel_b),
      .C_SEL_RB    (sel_c),
      .WE_IN       (we_in),
      .Y_X_KMX_SEL (ysel),
      .Y_KMX_IN    (y_in),
      .ALUC_IN     (aluc),
      .SHIFTER_SEL (shsel),
      .W_OUT       (w_out),
      .OUT_VALID   (out_valid),
      .CY_OUT      (cy_out),
      .Z_OUT       (z_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int w;
      bit cy;
      bit z;
      int cyc;
   } exp_t;
   exp_t q[$];

   int n_tests = 0;
   int n_fail  = 0;

   int mregs [NR];
   bit mcy = 1'b0;
   bit mz  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Architectural reference: one op fully applied before the next.
   function automatic int model_alu(input int op, input int sh, input int a, input int b);
      int r;
      int s;
      bit c;
      c = mcy;
      r = a;
      case (op)
         1:  r = b;
         2:  begin s = a + b;       r = s & M; c = (s > M); end
         3:  begin s = a + b + int'(mcy); r = s & M; c = (s > M); end
         4:  begin r = (a - b) & M; c = (a < b); end
         5:  begin r = (a - b - int'(mcy)) & M; c = (a < b + int'(mcy)); end
         6:  r = a & b;
         7:  r = a | b;
         8:  r = a ^ b;
         9:  r = ~a & M;
         10: begin s = a + 1; r = s & M; c = (s > M); end
         11: begin r = (a - 1) & M; c = (a == 0); end
         default: r = a;
      endcase
      case (sh)
         1: begin c = r[15]; r = (r << 1) & M; end
         2: begin c = r[0];  r = r >> 1; end
         3: begin c = r[0];  r = (r >> 1) | (int'(r[0]) << 15); end
         default: ;
      endcase
      mcy = c;
      return r;
   endfunction

   // Called at posedge+1; returns at posedge+1 after acceptance.
   task automatic issue(input int op, input int sh, input int a, input int b, input int c,
                        input bit we, input bit ys, input int y, input bit track,
                        output int stalls);
      bit   rdy;
      int   ra, rb, res;
      exp_t e;
      aluc     = op[3:0];
      shsel    = sh[1:0];
      sel_a    = a[AW-1:0];
      sel_b    = b[AW-1:0];
      sel_c    = c[AW-1:0];
      we_in    = we;
      ysel     = ys;
      y_in     = y[DW-1:0];
      in_valid = 1'b1;
      stalls   = 0;
      rdy      = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         if (rdy) break;
         stalls++;
      end
      #1;
      in_valid = 1'b0;
      if (!rdy) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: IN_READY stayed %b, expected 1 within 6 cycles", in_ready);
      end else if (track) begin
         ra  = (a == 0) ? 0 : mregs[a];
         rb  = ys ? (y & M) : ((b == 0) ? 0 : mregs[b]);
         res = model_alu(op, sh, ra, rb);
         mz  = (res == 0);
         if (we && c != 0) mregs[c] = res;
         e.w   = res;
         e.cy  = mcy;
         e.z   = mz;
         e.cyc = cyc + 1;
         q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Monitor
   exp_t me;
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_out_valid: got OUT_VALID=1 W_OUT=%h, expected no output", w_out);
         end else begin
            me = q.pop_front();
            chk("w_out",   {16'h0, w_out}, me.w);
            chk("cy_out",  {31'h0, cy_out}, {31'h0, me.cy});
            chk("z_out",   {31'h0, z_out},  {31'h0, me.z});
            chk("latency", cyc, me.cyc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
      $fatal(1);
   end

   initial begin
      int st;
      for (int i = 0; i < NR; i++) mregs[i] = 0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_w_out",     {16'h0, w_out}, 0);
      chk("rst_out_valid", {31'h0, out_valid}, 0);
      chk("rst_cy",        {31'h0, cy_out}, 0);
      chk("rst_z",         {31'h0, z_out}, 0);
      chk("rst_in_ready",  {31'h0, in_ready}, 1);
      @(posedge clk);
      #1;

      // Write constant to r1
      issue(1, 0, 0, 0, 1, 1, 1, 'h00FF, 1, st);
      // r1=FFFF, r2=1, ADD r3, ADC r4=r0+r0+CY
      issue(1, 0, 0, 0, 1, 1, 1, 'hFFFF, 1, st);
      issue(1, 0, 0, 0, 2, 1, 1, 'h0001, 1, st);
      issue(2, 0, 1, 2, 3, 1, 0, 0, 1, st);
      issue(3, 0, 0, 0, 4, 1, 0, 0, 1, st);
      // Back-to-back hazards on A and on B
      issue(1, 0, 0, 0, 5, 1, 1, 'h1234, 1, st);
      issue(2, 0, 1, 2, 5, 1, 0, 0, 1, st);
      issue(0, 0, 5, 0, 6, 1, 0, 0, 1, st);
      chk("hazard_a_stalls", st, EXP_STALL);
      issue(8, 0, 1, 6, 7, 1, 0, 0, 1, st);
      chk("hazard_b_stalls", st, EXP_STALL);
      // Shifts
      issue(1, 0, 0, 0, 1, 1, 1, 'h8001, 1, st);
      issue(0, 1, 1, 0, 0, 0, 0, 0, 1, st);
      issue(1, 0, 0, 0, 8, 1, 1, 'h0001, 1, st);
      issue(0, 3, 8, 0, 0, 0, 0, 0, 1, st);
      issue(0, 2, 8, 0, 0, 0, 0, 0, 1, st);
      // Write to r0 is dropped but still reported
      issue(1, 0, 0, 0, 0, 1, 1, 'h1234, 1, st);
      issue(0, 0, 0, 0, 9, 1, 0, 0, 1, st);
      // Leave CY=1, then reset while an op sits in execute
      issue(2, 0, 1, 1, 11, 1, 0, 0, 1, st);
      idle(4);
      chk("pre_reset_drain", q.size(), 0);
      issue(1, 1, 0, 0, 10, 1, 1, 'hBEEF, 0, st);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      for (int i = 0; i < NR; i++) mregs[i] = 0;
      mcy = 1'b0;
      mz  = 1'b0;
      q.delete();
      @(negedge clk);
      chk("midrst_out_valid", {31'h0, out_valid}, 0);
      chk("midrst_cy",        {31'h0, cy_out}, 0);
      chk("midrst_z",         {31'h0, z_out}, 0);
      chk("midrst_w_out",     {16'h0, w_out}, 0);
      @(posedge clk);
      #1;
      issue(0, 0, 10, 0, 0, 0, 0, 0, 1, st);
      issue(0, 0, 1, 0, 0, 0, 0, 0, 1, st);

      // Randomised traffic with a small register window to provoke hazards
      for (int n = 0; n < 300; n++) begin
         issue($urandom_range(0, 15), $urandom_range(0, 3),
               $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, M), 1, st);
         if ($urandom_range(0, 3) == 0) idle(1);
      end

      for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
      @(negedge clk);
      chk("final_drain", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_alu_regfile_pipe
`default_nettype wire
